// File: rtl/sblock_cfg_pkg.sv
// Shared constants, state type and frame layout for the switch-block config loader.
package sblock_cfg_pkg;

  localparam int unsigned FRAME_W  = 18;
  localparam int unsigned HALF_W   = 9;
  localparam int unsigned BITCNT_W = 5;
  localparam int unsigned IDLE_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  // One switch-block frame: horizontal half in the MSBs, vertical half in the LSBs.
  typedef struct packed {
    logic [HALF_W-1:0] horiz;
    logic [HALF_W-1:0] vert;
  } sb_frame_t;

endpackage

// File: rtl/sblock_cfg_deser.sv
// Serial-to-parallel frame assembler: shift register, bit counter, frame-complete flag.
import sblock_cfg_pkg::*;

module sblock_cfg_deser (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      clr_i,
  input  logic      shift_en_i,
  input  logic      bit_i,
  output sb_frame_t frame_o,
  output logic      frame_done_c
);

  logic [FRAME_W-1:0]  frame_q;
  logic [BITCNT_W-1:0] bit_cnt_q;

  // Shift accepted bits in LSB-side (frame arrives MSB first) and count them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_q   <= '0;
      bit_cnt_q <= '0;
    end else if (clr_i) begin
      bit_cnt_q <= '0;
    end else if (shift_en_i) begin
      frame_q   <= {frame_q[FRAME_W-2:0], bit_i};
      bit_cnt_q <= bit_cnt_q + BITCNT_W'(1);
    end
  end

  // The bit being accepted right now is the last one of the frame.
  assign frame_done_c = shift_en_i && (bit_cnt_q == BITCNT_W'(FRAME_W - 1));
  assign frame_o      = frame_q;

endmodule

// File: rtl/sblock_cfg_loader.sv
// Loads serial configuration frames into a chain of switch blocks, one write per block.
import sblock_cfg_pkg::*;

module sblock_cfg_loader #(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  cfg_v_i,
  input  logic                  cfg_data_i,
  output logic                  cfg_ready_o,
  output logic [FRAME_W-1:0]    sb_bits_o,
  output logic [NUM_BLOCKS-1:0] sb_wr_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);

  cfg_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              accept;
  logic              deser_clr;
  logic              frame_done;
  sb_frame_t         frame;

  sblock_cfg_deser u_deser (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clr_i        (deser_clr),
    .shift_en_i   (accept),
    .bit_i        (cfg_data_i),
    .frame_o      (frame),
    .frame_done_c (frame_done)
  );

  // State, block index and idle counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state logic; abort overrides everything after the per-state decision.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    idle_d    = idle_q;
    deser_clr = 1'b0;
    accept    = (state_q == ST_SHIFT) && cfg_v_i;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d   = ST_SHIFT;
          idx_d     = '0;
          idle_d    = '0;
          deser_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          idle_d = '0;
          if (frame_done) state_d = ST_WRITE;
        end else if (idle_q == IDLE_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_WRITE: begin
        deser_clr = 1'b1;
        idle_d    = '0;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) state_d = ST_IDLE;
  end

  // Output decode; reset and abort force outputs quiet within the same cycle.
  always_comb begin
    cfg_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    sb_bits_o   = '0;
    sb_wr_en_o  = '0;
    if (!reset_i) begin
      cfg_ready_o = (state_q == ST_SHIFT);
      busy_o      = (state_q == ST_SHIFT) || (state_q == ST_WRITE);
      done_o      = (state_q == ST_DONE);
      err_o       = (state_q == ST_ERR);
      sb_bits_o   = frame;
      if ((state_q == ST_WRITE) && !abort_i) begin
        sb_wr_en_o = NUM_BLOCKS'(1) << idx_q;
      end
    end
  end

endmodule

// File: doc/sblock_cfg_loader.md
SBLOCK_CFG_LOADER -- requirements
Module: sblock_cfg_loader

Interface
REQ-001 The block SHALL take parameter NUM_BLOCKS, default 4, meaning the number of switch blocks in the configuration chain (range 1..16).
REQ-002 The block SHALL take parameter TIMEOUT, default 64, meaning the number of consecutive idle cycles in SHIFT before an error (range 2..255).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: begin a configuration pass.
REQ-006 The block SHALL have port abort_i, input, 1 bit: cancel the pass and return to IDLE.
REQ-007 The block SHALL have port cfg_v_i, input, 1 bit: the serial configuration bit is valid.
REQ-008 The block SHALL have port cfg_data_i, input, 1 bit: the serial configuration bit, frame MSB first.
REQ-009 The block SHALL have port cfg_ready_o, output, 1 bit: the loader accepts a bit when cfg_v_i and cfg_ready_o are both 1.
REQ-010 The block SHALL have port sb_bits_o, output, 18 bits: the frame driven to every switch block's bits input (9 horizontal MSBs, 9 vertical LSBs).
REQ-011 The block SHALL have port sb_wr_en_o, output, NUM_BLOCKS bits: one-hot write enable per switch block.
REQ-012 The block SHALL have ports busy_o, done_o and err_o, each output, 1 bit: pass in progress, pass completed and pass failed respectively.

Function
REQ-013 The block SHALL implement the states IDLE, SHIFT, WRITE, DONE and ERR.
REQ-014 In IDLE, DONE and ERR, start_i=1 SHALL transition to SHIFT and clear the bit counter, block index and idle counter.
REQ-015 In SHIFT, cfg_ready_o SHALL be 1; it SHALL be 0 in every other state.
REQ-016 In SHIFT, each accepted bit SHALL shift into the frame register LSB-side (frame <= {frame[16:0], cfg_data_i}) and increment the 5-bit bit counter.
REQ-017 Acceptance of the 18th bit of a frame SHALL transition to WRITE on the next edge, giving a latency of exactly 1 cycle from the last accepted bit to the wr_en assertion.
REQ-018 In WRITE, which lasts exactly 1 cycle, sb_wr_en_o SHALL equal 1 << block index, and sb_bits_o SHALL equal the assembled frame.
REQ-019 From WRITE, if block index = NUM_BLOCKS-1 the block SHALL go to DONE; otherwise it SHALL increment the block index, clear the bit counter and return to SHIFT.
REQ-020 sb_wr_en_o SHALL be all-zero in every state except WRITE, and at most one of its bits SHALL be 1 in any cycle.
REQ-021 sb_bits_o SHALL be driven from the frame register and SHALL remain stable during the WRITE cycle.
REQ-022 In SHIFT, the idle counter SHALL increment on each cycle with cfg_v_i=0 and clear on each accepted bit.
REQ-023 When the idle counter reaches TIMEOUT, the block SHALL go to ERR with no wr_en asserted.
REQ-024 busy_o SHALL be 1 exactly in SHIFT and WRITE; done_o exactly in DONE; err_o exactly in ERR. DONE and ERR SHALL hold until start_i, abort_i or reset_i.
REQ-025 abort_i=1 SHALL force IDLE from any state on the next edge and SHALL suppress sb_wr_en_o combinationally in that cycle. abort_i SHALL take priority over start_i, and over timeout.
REQ-026 start_i SHALL be ignored in SHIFT and WRITE.
REQ-027 With NUM_BLOCKS=1, a pass SHALL be exactly 1 frame: WRITE followed by DONE.

Reset
REQ-028 reset_i=1 SHALL put the block in IDLE, with frame register, bit counter, block index and idle counter at 0.
REQ-029 During reset, all outputs SHALL be 0: sb_bits_o=0, sb_wr_en_o=0, cfg_ready_o=0, busy_o=0, done_o=0, err_o=0.
REQ-030 Reset asserted mid-pass SHALL take precedence over all inputs and SHALL produce no write in that cycle.

Structure
REQ-031 Package sblock_cfg_pkg SHALL hold FRAME_W=18, HALF_W=9 and the state enum type.
REQ-032 One sub-module, sblock_cfg_deser, SHALL hold the shift register, the bit counter and the frame-complete flag; the FSM, block index and timeout SHALL live in sblock_cfg_loader.

Verification
REQ-033 NUM_BLOCKS=4, start, 4 back-to-back frames of 18'b111000111111000111 -> four 1-cycle wr_en pulses 0001, 0010, 0100, 1000 with sb_bits_o=18'h38FC7, then done_o=1.
REQ-034 A gapped stream (cfg_v_i low for 10 cycles between bits, TIMEOUT=64) -> frames are assembled correctly and there is no error.
REQ-035 The stream stops after 7 bits with TIMEOUT=64 -> err_o=1 exactly 64 cycles after the last accepted bit, and sb_wr_en_o is never nonzero.
REQ-036 abort_i together with start_i in the WRITE cycle of frame 2 -> sb_wr_en_o=0 that cycle, IDLE next, and busy_o=0.
REQ-037 reset_i asserted mid-frame, then start and one full pass -> the pass completes identically to REQ-033 and no partial-frame bits leak into it.
REQ-038 start_i pulsed in DONE -> a new pass begins in SHIFT at block index 0, and done_o drops on the next cycle.
